switch_demux: RTL and testbench

- Reverse-direction counterpart of the 4:1 data switch: one input stream is fanned out to up to four destination ports (a, b, c, d).
- Each word carries a 4-bit destination mask, so it can go to one port (unicast), several ports (multicast) or all four (broadcast).
- Sits on the router-cluster side of the hierarchical mesh, feeding GLB/PE-cluster links.
- An input FIFO decouples the producer from the consumers; multicast completion is tracked per port.

---
 rtl/noc_pkg.sv | 16 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/switch_demux.sv | 84 ++++++++
 tb/tb_switch_demux.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port count, port indices, destination mask type.
// Combinational helpers only; no state and no flow control.
package noc_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;
  localparam int PORT_C = 2;
  localparam int PORT_D = 3;

  typedef logic [NUM_PORTS-1:0] mask_t;

  // True when every port requested in need is present in got.
  function automatic logic mask_covers(input mask_t got, input mask_t need);
    return (got & need) == need;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; the head is readable combinationally in the cycle after the push.
// A push while full and a pop while empty are ignored; full is purely state-based.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/switch_demux.sv
// 1:4 demux with per-word destination mask; head visible one cycle after push.
// Head-of-line blocking: a word pops only once every selected port has accepted it.
module switch_demux
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  mask_t                                in_sel,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_data,
  output mask_t                                out_valid,
  input  mask_t                                out_ready,
  output logic [CNT_WIDTH-1:0]                 drop_count,
  output logic                                 busy
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    mask_t                 sel;
  } entry_t;

  entry_t                   wr_entry;
  entry_t                   head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     rst_q;
  logic                     push;
  logic                     pop;
  logic                     head_vld;
  mask_t                    done;
  mask_t                    fire;
  logic [CNT_WIDTH-1:0]     drop_cnt;

  assign wr_entry = '{data: in_data, sel: in_sel};

  // rst_q holds off the producer for one extra cycle after reset.
  assign in_ready = !fifo_full && !rst && !rst_q;
  assign push     = in_valid && in_ready;
  assign head_vld = !fifo_empty && !rst;
  assign out_valid = head_vld ? (head.sel & ~done) : '0;
  assign fire     = out_valid & out_ready;
  assign pop      = head_vld && mask_covers(done | fire, head.sel);

  assign busy       = (fifo_count != '0) && !rst;
  assign drop_count = rst ? '0 : drop_cnt;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) out_data[i] = head.data;
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A word with an empty mask pops on its first head cycle and is counted as dropped.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      done     <= '0;
      drop_cnt <= '0;
    end else begin
      done <= pop ? '0 : (done | fire);
      if (pop && head.sel == '0 && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_switch_demux.sv
// Directed bench for switch_demux: per-port expected-data queues filled at push time,
// drained by a monitor on every observed fire; cycle-level checks done inline.
module tb_switch_demux;
  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       in_data;
  logic [3:0]        in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [3:0][15:0]  out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [7:0]        drop_count;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  logic [15:0] expq [4][$];
  logic [15:0] mon_exp;
  logic [3:0]  tab [16] = '{4'h1, 4'h3, 4'hF, 4'h8, 4'h6, 4'h2, 4'hC, 4'h5,
                            4'hA, 4'h4, 4'h9, 4'hE, 4'h7, 4'hB, 4'hD, 4'h1};

  switch_demux #(.DATA_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one word until accepted (bounded); expected data queued per selected port.
  task automatic push_word(input logic [15:0] d, input logic [3:0] s);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (s[i]) expq[i].push_back(d);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: word %h never accepted", d);
    end
  endtask

  // Scoreboard monitor: every fire must match the oldest expected word for that port.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
          if (expq[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_fire port%0d: got %h expected no delivery", i, out_data[i]);
          end else begin
            mon_exp = expq[i].pop_front();
            chk($sformatf("port%0d_data", i), 32'(out_data[i]), 32'(mon_exp));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] full_exp [5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h5};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    tick; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 0);
    tick;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 1);

    // unicast
    tick; out_ready = 4'hF;
    push_word(16'h1234, 4'b0100);
    @(negedge clk);
    chk("uni_valid", 32'(out_valid), 32'h4);
    chk("uni_busy", 32'(busy), 1);
    tick;
    @(negedge clk);
    chk("uni_busy_after", 32'(busy), 0);
    chk("uni_valid_after", 32'(out_valid), 0);

    // staggered multicast
    tick; out_ready = 4'b0001;
    push_word(16'hBEEF, 4'b1011);
    @(negedge clk); chk("mc_valid0", 32'(out_valid), 32'hB);
    tick; out_ready = 4'b1000;
    @(negedge clk); chk("mc_valid1", 32'(out_valid), 32'hA);
    tick; out_ready = 4'b0010;
    @(negedge clk); chk("mc_valid2", 32'(out_valid), 32'h2);
    chk("mc_busy", 32'(busy), 1);
    tick;
    @(negedge clk); chk("mc_valid_done", 32'(out_valid), 0);
    chk("mc_busy_done", 32'(busy), 0);

    // full / backpressure
    tick; out_ready = 4'h0;
    for (int i = 0; i < 4; i++) push_word(16'hA000 + 16'(i), 4'hF);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_valid", 32'(out_valid), 32'hF);
    tick; in_data = 16'hA004; in_sel = 4'h5; in_valid = 1'b1;
    @(negedge clk); chk("full_held", 32'(in_ready), 0);
    tick;
    fork
      push_word(16'hA004, 4'h5);
      begin
        out_ready = 4'hF;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk($sformatf("drain_valid%0d", c), 32'(out_valid), 32'(full_exp[c]));
        end
      end
    join
    tick;
    @(negedge clk);
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_busy", 32'(busy), 0);

    // drops
    tick; out_ready = 4'hF;
    for (int i = 0; i < 3; i++) push_word(16'h0D00 + 16'(i), 4'h0);
    @(negedge clk); chk("drop_no_valid", 32'(out_valid), 0);
    tick;
    @(negedge clk);
    chk("drop_count3", 32'(drop_count), 3);
    chk("drop_busy", 32'(busy), 0);
    for (int i = 0; i < 260; i++) push_word(16'(i), 4'h0);
    tick; tick;
    @(negedge clk); chk("drop_saturate", 32'(drop_count), 32'hFF);

    // reset mid-multicast
    tick; out_ready = 4'b0001;
    push_word(16'h7777, 4'hF);
    @(negedge clk); chk("rmc_valid", 32'(out_valid), 32'hF);
    tick; out_ready = 4'h0; rst = 1'b1;
    @(negedge clk);
    chk("rmc_rst_valid", 32'(out_valid), 0);
    chk("rmc_rst_busy", 32'(busy), 0);
    chk("rmc_rst_drop", 32'(drop_count), 0);
    tick; rst = 1'b0; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) expq[i].delete();
    @(negedge clk);
    chk("rmc_after_valid", 32'(out_valid), 0);
    chk("rmc_after_ready", 32'(in_ready), 0);
    chk("rmc_after_drop", 32'(drop_count), 0);
    tick;
    push_word(16'h0055, 4'b0001);
    @(negedge clk); chk("rmc_new_valid", 32'(out_valid), 32'h1);
    tick;
    @(negedge clk); chk("rmc_new_done", 32'(out_valid), 0);

    // back-to-back streaming
    tick;
    in_data = 16'h5000; in_sel = tab[0]; in_valid = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k > 0) chk($sformatf("stream_valid%0d", k - 1), 32'(out_valid), 32'(tab[k-1]));
      if (k < 16) begin
        chk("stream_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) if (tab[k][i]) expq[i].push_back(16'h5000 + 16'(k));
      end
      @(posedge clk); #1;
      if (k < 15) begin
        in_data = 16'h5000 + 16'(k + 1);
        in_sel  = tab[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    tick; tick;
    @(negedge clk);
    chk("final_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("leftover_port%0d", i), 32'(expq[i].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
